// File: rtl/i2lbs_pkg.sv
// Shared state encoding and default widths for the sliding-window scheduler.
package i2lbs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAM  = 2'd1,
    ST_INSPECT = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  localparam int DEF_DATA_WIDTH_16 = 16;
  localparam int DEF_DATA_WIDTH_12 = 12;

endpackage

// File: rtl/i2lbs_window_scheduler_if.sv
// Pixel stream, classifier handshake and candidate queue signals of the scheduler.
interface i2lbs_window_scheduler_if
  import i2lbs_pkg::*;
#(
  parameter int DATA_WIDTH_16 = DEF_DATA_WIDTH_16,
  parameter int DATA_WIDTH_12 = DEF_DATA_WIDTH_12
);
  logic                     i_frame_start;
  logic                     i_pixel_valid;
  logic                     o_pixel_ready;
  logic [DATA_WIDTH_16-1:0] i_pixel;
  logic                     o_mem_wen;
  logic [DATA_WIDTH_16-1:0] o_mem_pixel;
  logic                     o_classifier_enable;
  logic                     i_inspect_done;
  logic                     i_candidate;
  logic                     o_cand_valid;
  logic                     i_cand_ready;
  logic [DATA_WIDTH_12-1:0] o_cand_x;
  logic [DATA_WIDTH_12-1:0] o_cand_y;
  logic                     o_frame_done;
  logic                     o_overflow;
  logic                     o_busy;

  modport master (
    output i_frame_start, i_pixel_valid, i_pixel, i_inspect_done, i_candidate, i_cand_ready,
    input  o_pixel_ready, o_mem_wen, o_mem_pixel, o_classifier_enable, o_cand_valid,
           o_cand_x, o_cand_y, o_frame_done, o_overflow, o_busy
  );

  modport slave (
    input  i_frame_start, i_pixel_valid, i_pixel, i_inspect_done, i_candidate, i_cand_ready,
    output o_pixel_ready, o_mem_wen, o_mem_pixel, o_classifier_enable, o_cand_valid,
           o_cand_x, o_cand_y, o_frame_done, o_overflow, o_busy
  );
endinterface

// File: rtl/i2lbs_cand_fifo.sv
// Candidate queue of {x,y} window origins; a push into a full queue is dropped
// unless a pop frees a slot in the same cycle.
module i2lbs_cand_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             drop_o
);
  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_FULL);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && !do_push;
  assign dout_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + AW'(1);
    if (do_pop)  rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries data only; occupancy is tracked by the reset control above.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/i2lbs_window_scheduler.sv
// Raster-order window scheduler: streams pixels to integral memory, pauses for the
// classifier at each strided window position and queues positive window origins.
module i2lbs_window_scheduler
  import i2lbs_pkg::*;
#(
  parameter int DATA_WIDTH_16   = DEF_DATA_WIDTH_16,
  parameter int DATA_WIDTH_12   = DEF_DATA_WIDTH_12,
  parameter int INTEGRAL_WIDTH  = 3,
  parameter int INTEGRAL_HEIGHT = 3,
  parameter int FRAME_WIDTH     = 10,
  parameter int FRAME_HEIGHT    = 10,
  parameter int STRIDE          = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input logic                      clk,
  input logic                      reset,
  i2lbs_window_scheduler_if.slave  bus
);
  localparam int            CW      = DATA_WIDTH_12;
  localparam int            PW      = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [CW-1:0] X_START = CW'(INTEGRAL_WIDTH - 1);
  localparam logic [CW-1:0] Y_START = CW'(INTEGRAL_HEIGHT - 1);
  localparam logic [CW-1:0] X_LAST  = CW'(FRAME_WIDTH - 1);
  localparam logic [CW-1:0] Y_LAST  = CW'(FRAME_HEIGHT - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(STRIDE - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   x_q, x_d, y_q, y_d;
  logic [PW-1:0]   px_q, px_d, py_q, py_d;
  logic [CW-1:0]   wx_q, wx_d, wy_q, wy_d;
  logic            last_q, last_d;
  logic            en_q, en_d;
  logic            ovf_q, ovf_d;
  logic            xfer, eligible, at_last, push, pop, frame_done;
  logic            empty, full, drop;
  logic [2*CW-1:0] head;

  // Phase only starts counting once the window fits; it wraps at STRIDE-1.
  function automatic logic [PW-1:0] phase_step(input logic [PW-1:0] ph, input logic active);
    if (!active)        return '0;
    if (ph == PH_LAST)  return '0;
    return ph + PW'(1);
  endfunction

  assign xfer     = (state_q == ST_STREAM) && bus.i_pixel_valid;
  assign at_last  = (x_q == X_LAST) && (y_q == Y_LAST);
  assign eligible = xfer && (x_q >= X_START) && (y_q >= Y_START) && (px_q == '0) && (py_q == '0);
  assign pop      = !empty && bus.i_cand_ready;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    px_d       = px_q;
    py_d       = py_q;
    wx_d       = wx_q;
    wy_d       = wy_q;
    last_d     = last_q;
    en_d       = en_q;
    ovf_d      = ovf_q | drop;
    push       = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_frame_start) begin
          state_d = ST_STREAM;
          x_d     = '0;
          y_d     = '0;
          px_d    = '0;
          py_d    = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          if (x_q == X_LAST) begin
            x_d  = '0;
            px_d = '0;
            y_d  = y_q + CW'(1);
            py_d = phase_step(py_q, y_q >= Y_START);
          end else begin
            x_d  = x_q + CW'(1);
            px_d = phase_step(px_q, x_q >= X_START);
          end
          if (eligible) begin
            state_d = ST_INSPECT;
            en_d    = 1'b1;
            wx_d    = x_q - X_START;
            wy_d    = y_q - Y_START;
            last_d  = at_last;
          end else if (at_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_INSPECT: begin
        if (bus.i_inspect_done) begin
          en_d    = 1'b0;
          push    = bus.i_candidate;
          state_d = last_q ? ST_DRAIN : ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (empty) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
      wx_q    <= '0;
      wy_q    <= '0;
      last_q  <= 1'b0;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      px_q    <= px_d;
      py_q    <= py_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      last_q  <= last_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
    end
  end

  i2lbs_cand_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * CW)
  ) u_cand_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   ({wx_q, wy_q}),
    .pop_i   (pop),
    .dout_o  (head),
    .empty_o (empty),
    .full_o  (full),
    .drop_o  (drop)
  );

  // Head coordinates are forced to zero while the queue is empty so reset leaves them clean.
  assign bus.o_pixel_ready       = (state_q == ST_STREAM);
  assign bus.o_mem_wen           = xfer;
  assign bus.o_mem_pixel         = xfer ? bus.i_pixel : '0;
  assign bus.o_classifier_enable = en_q;
  assign bus.o_cand_valid        = !empty;
  assign bus.o_cand_x            = empty ? '0 : head[2*CW-1:CW];
  assign bus.o_cand_y            = empty ? '0 : head[CW-1:0];
  assign bus.o_frame_done        = frame_done;
  assign bus.o_overflow          = ovf_q;
  assign bus.o_busy              = (state_q != ST_IDLE);

endmodule

// File: doc/i2lbs_window_scheduler.md
I2LBS_WINDOW_SCHEDULER -- requirements
Module: i2lbs_window_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH_16, default 16, meaning pixel width.
REQ-002 SHALL have parameter DATA_WIDTH_12, default 12, meaning coordinate width.
REQ-003 SHALL have parameters INTEGRAL_WIDTH and INTEGRAL_HEIGHT, default 3 each, meaning window size in pixels.
REQ-004 SHALL have parameters FRAME_WIDTH and FRAME_HEIGHT, default 10 each, meaning resized frame size.
REQ-005 SHALL have parameter STRIDE, default 1, range 1..INTEGRAL_WIDTH, meaning window step in x and y.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, power of two, meaning candidate queue depth.
REQ-007 SHALL use one clock; reset is asynchronous and active-high.
REQ-008 Ports, as name direction width meaning:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- i_frame_start  in  1  start-of-frame pulse.
- i_pixel_valid  in  1  pixel offered.
- o_pixel_ready  out  1  pixel accepted when high with valid.
- i_pixel  in  DATA_WIDTH_16  resized pixel, raster order.
- o_mem_wen  out  1  integral memory write strobe.
- o_mem_pixel  out  DATA_WIDTH_16  pixel to memory.
- o_classifier_enable  out  1  classifier run request.
- i_inspect_done  in  1  classifier finished.
- i_candidate  in  1  classifier verdict.
- o_cand_valid  out  1  queue head valid.
- i_cand_ready  in  1  consumer pops head.
- o_cand_x, o_cand_y  out  DATA_WIDTH_12  window top-left.
- o_frame_done  out  1  one-cycle end-of-frame pulse.
- o_overflow  out  1  sticky candidate drop flag.
- o_busy  out  1  state not IDLE.

Function
REQ-009 SHALL implement states IDLE, STREAM, INSPECT, DRAIN.
REQ-010 SHALL leave IDLE for STREAM on i_frame_start.
- On that transition: clear x/y counters, stride phases and o_overflow.
REQ-011 SHALL ignore i_frame_start outside IDLE.
REQ-012 SHALL drive o_pixel_ready high only in STREAM.
- A pixel transfers on valid&&ready.
REQ-013 SHALL assert o_mem_wen combinationally on each transfer, with o_mem_pixel=i_pixel.
REQ-014 SHALL advance x on each transfer.
- x wraps at FRAME_WIDTH-1 to 0 and increments y.
REQ-015 SHALL mark a transfer eligible when all of the following hold:
- x>=INTEGRAL_WIDTH-1 and y>=INTEGRAL_HEIGHT-1.
- The x and y stride phases are both 0.
- Phases are counters, not modulo.
REQ-016 SHALL move to INSPECT on an eligible transfer.
- o_classifier_enable rises the next cycle and holds until i_inspect_done.
REQ-017 SHALL, on i_inspect_done in INSPECT, deassert enable the same edge.
- If i_candidate, push (x-(INTEGRAL_WIDTH-1), y-(INTEGRAL_HEIGHT-1)).
REQ-018 SHALL go to DRAIN after INSPECT if the inspected pixel was (FRAME_WIDTH-1, FRAME_HEIGHT-1), else to STREAM.
REQ-019 SHALL go STREAM->DRAIN on a non-eligible transfer of the last pixel.
REQ-020 SHALL pulse o_frame_done for one cycle in DRAIN once the queue is empty, then go to IDLE.
REQ-021 SHALL handle a push into a full queue as follows:
- Without a same-cycle pop: drop the entry and set o_overflow.
- With a same-cycle pop: pop and push both occur, no overflow.
REQ-022 SHALL present the queue head with o_cand_valid=!empty.
- Pop on o_cand_valid&&i_cand_ready.
- Pointers wrap modulo FIFO_DEPTH.
REQ-023 SHALL ignore i_inspect_done outside INSPECT.

Reset
REQ-024 SHALL on reset, at any state including mid-INSPECT, do the following:
- Enter IDLE.
- Empty the queue.
- Zero the counters.
- Drive all outputs 0: o_pixel_ready, o_mem_wen, o_classifier_enable, o_cand_valid, o_cand_x, o_cand_y, o_frame_done, o_overflow, o_busy.

Structure
REQ-025 SHALL place state encodings and default widths in shared package i2lbs_pkg.
REQ-026 SHALL instantiate one sub-module, i2lbs_cand_fifo, holding {x,y} entries.

Verification
REQ-027 Bench SHALL cover the following:
- 6x6 frame, 3x3 window, STRIDE=1, i_candidate=1, i_cand_ready=1 -> 16 candidates, (0,0) first, (3,3) last; one o_frame_done.
- Same with STRIDE=2 -> exactly 4 candidates: (0,0),(2,0),(0,2),(2,2).
- STRIDE=1, i_cand_ready=0, FIFO_DEPTH=4 -> 4 queued, o_overflow=1; DRAIN holds until 4 pops, then o_frame_done.
- Reset asserted two cycles into INSPECT -> all outputs 0 next edge; new i_frame_start restarts at (0,0).
- Random i_pixel_valid gaps plus i_frame_start pulsed mid-STREAM -> same candidate list as gap-free; restart ignored.
